// File: rtl/cpu_pkg.sv
//==============================================================================
// Module      : cpu_pkg
// Description : Shared CPU definitions: RV32I load/store funct3 codes, data
//               memory FSM states and the access-latency ceiling.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package cpu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int LATENCY_MAX = 15;

    typedef enum logic [1:0] {
        DM_IDLE = 2'd0,
        DM_BUSY = 2'd1,
        DM_DONE = 2'd2
    } dm_state_t;

endpackage

`default_nettype wire

// File: rtl/dmem_ctrl_if.sv
//==============================================================================
// Module      : dmem_ctrl_if
// Description : Memory-stage request/response bundle between core and dmem_ctrl.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface dmem_ctrl_if;

    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        fault;

    modport master (
        output mem_read, mem_write, funct3, addr, wdata,
        input  rdata, stall, fault
    );

    modport slave (
        input  mem_read, mem_write, funct3, addr, wdata,
        output rdata, stall, fault
    );

endinterface

`default_nettype wire

// File: rtl/dmem_ram.sv
//==============================================================================
// Module      : dmem_ram
// Description : Single-port DEPTH_WORDS x 32 RAM, per-byte write enable and
//               registered read. Only the read register is reset.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module dmem_ram #(
    parameter int DEPTH_WORDS = 512
) (
    input  wire logic                           i_clk,
    input  wire logic                           i_rst_n,
    input  wire logic                           i_re,
    input  wire logic [3:0]                     i_we,
    input  wire logic [$clog2(DEPTH_WORDS)-1:0] i_addr,
    input  wire logic [31:0]                    i_wdata,
    output logic      [31:0]                    o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_q;

    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_we[b]) begin
                r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    // The read register only moves on an explicit read, so it keeps the last
    // loaded word for as long as no further load is issued.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= '0;
        end else if (i_re) begin
            r_q <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_q;

endmodule

`default_nettype wire

// File: rtl/dmem_ctrl.sv
//==============================================================================
// Module      : dmem_ctrl
// Description : Data-memory responder for the memory stage: fixed-latency
//               load/store with stall, fault detection and load extension.
//               Optional DMEM_PERF_EN adds saturating load/store counters.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module dmem_ctrl
    import cpu_pkg::*;
#(
    parameter int DEPTH_WORDS = 512,
    parameter int LATENCY     = 2
) (
    input  wire logic        i_clk,
    input  wire logic        i_rst_n,
    dmem_ctrl_if.slave       dmem
`ifdef DMEM_PERF_EN
    ,
    output logic      [15:0] o_load_cnt,
    output logic      [15:0] o_store_cnt
`endif
);

    localparam int         AW         = $clog2(DEPTH_WORDS);
    localparam logic [3:0] C_CNT_INIT = 4'(LATENCY - 1);

    dm_state_t   r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;

    logic [AW-1:0] r_idx;
    logic [1:0]    r_off;
    logic [2:0]    r_funct3;
    logic [31:0]   r_wdata;
    logic          r_write;

    logic [2:0]    r_ld_f3;
    logic [1:0]    r_ld_off;

    logic          w_req;
    logic          w_f3_ok;
    logic          w_misalign;
    logic          w_fault;
    logic          w_accept;
    logic          w_commit;
    logic          w_idle;

    logic          w_c_write;
    logic [2:0]    w_c_f3;
    logic [1:0]    w_c_off;
    logic [AW-1:0] w_c_idx;
    logic [31:0]   w_c_wdata;
    logic [3:0]    w_be;
    logic [31:0]   w_lane_data;
    logic [31:0]   w_ram_q;
    logic          w_unused_addr;

    assign w_unused_addr = ^dmem.addr[31:AW+2];

    // Requests are ignored while held in reset so the core sees a quiet port.
    assign w_idle     = (r_state == DM_IDLE);
    assign w_req      = i_rst_n && (dmem.mem_read || dmem.mem_write);
    assign w_f3_ok    = dmem.mem_write ? (dmem.funct3 inside {F3_B, F3_H, F3_W})
                                       : (dmem.funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    assign w_misalign = ((dmem.funct3[1:0] == 2'b01) && dmem.addr[0]) ||
                        ((dmem.funct3[1:0] == 2'b10) && (dmem.addr[1:0] != 2'b00));
    assign w_fault    = w_idle && w_req &&
                        ((dmem.mem_read && dmem.mem_write) || !w_f3_ok || w_misalign);
    assign w_accept   = w_idle && w_req && !w_fault;

    assign dmem.fault = w_fault;
    assign dmem.stall = w_accept || (r_state == DM_BUSY);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= DM_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_commit    = 1'b0;
        case (r_state)
            DM_IDLE: begin
                if (w_accept) begin
                    if (LATENCY == 1) begin
                        w_state_nxt = DM_DONE;
                        w_cnt_nxt   = 4'd0;
                        w_commit    = 1'b1;
                    end else begin
                        w_state_nxt = DM_BUSY;
                        w_cnt_nxt   = C_CNT_INIT;
                    end
                end
            end
            DM_BUSY: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt = DM_DONE;
                    w_commit    = 1'b1;
                end
            end
            DM_DONE: begin
                w_state_nxt = DM_IDLE;
            end
            default: begin
                w_state_nxt = DM_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idx    <= '0;
            r_off    <= 2'd0;
            r_funct3 <= F3_W;
            r_wdata  <= '0;
            r_write  <= 1'b0;
        end else if (w_accept) begin
            r_idx    <= dmem.addr[AW+1:2];
            r_off    <= dmem.addr[1:0];
            r_funct3 <= dmem.funct3;
            r_wdata  <= dmem.wdata;
            r_write  <= dmem.mem_write;
        end
    end

    // With single-cycle latency the commit happens in the accepting IDLE cycle,
    // before the latched copy exists, so the live request is used instead.
    assign w_c_write = w_idle ? dmem.mem_write    : r_write;
    assign w_c_f3    = w_idle ? dmem.funct3       : r_funct3;
    assign w_c_off   = w_idle ? dmem.addr[1:0]    : r_off;
    assign w_c_idx   = w_idle ? dmem.addr[AW+1:2] : r_idx;
    assign w_c_wdata = w_idle ? dmem.wdata        : r_wdata;

    always_comb begin
        w_be        = 4'b1111;
        w_lane_data = w_c_wdata;
        case (w_c_f3[1:0])
            2'b00: begin
                w_be        = 4'b0001 << w_c_off;
                w_lane_data = {4{w_c_wdata[7:0]}};
            end
            2'b01: begin
                w_be        = w_c_off[1] ? 4'b1100 : 4'b0011;
                w_lane_data = {2{w_c_wdata[15:0]}};
            end
            default: begin
                w_be        = 4'b1111;
                w_lane_data = w_c_wdata;
            end
        endcase
    end

    dmem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_re    (w_commit && !w_c_write),
        .i_we    ((w_commit && w_c_write) ? w_be : 4'b0000),
        .i_addr  (w_c_idx),
        .i_wdata (w_lane_data),
        .o_rdata (w_ram_q)
    );

    // Size/offset of the most recent load, captured alongside the RAM read so
    // the extended result stays stable until the next load completes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ld_f3  <= F3_W;
            r_ld_off <= 2'd0;
        end else if (w_commit && !w_c_write) begin
            r_ld_f3  <= w_c_f3;
            r_ld_off <= w_c_off;
        end
    end

    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  off);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    load_extend = {{24{b[7]}}, b};
            F3_BU:   load_extend = {24'h0, b};
            F3_H:    load_extend = {{16{h[15]}}, h};
            F3_HU:   load_extend = {16'h0, h};
            default: load_extend = word;
        endcase
    endfunction

    assign dmem.rdata = load_extend(w_ram_q, r_ld_f3, r_ld_off);

`ifdef DMEM_PERF_EN
    logic [15:0] r_load_cnt;
    logic [15:0] r_store_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_load_cnt  <= 16'h0;
            r_store_cnt <= 16'h0;
        end else if (r_state == DM_DONE) begin
            if (r_write) begin
                if (r_store_cnt != 16'hFFFF) r_store_cnt <= r_store_cnt + 16'h1;
            end else begin
                if (r_load_cnt != 16'hFFFF) r_load_cnt <= r_load_cnt + 16'h1;
            end
        end
    end

    assign o_load_cnt  = r_load_cnt;
    assign o_store_cnt = r_store_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
//==============================================================================
// Module      : tb_dmem_ctrl
// Description : Self-checking bench for dmem_ctrl against a byte-level memory
//               model; honours DMEM_PERF_EN when defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_dmem_ctrl;
    import cpu_pkg::*;

    localparam int DEPTH = 512;
    localparam int LAT   = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_ctrl_if u_if ();

`ifdef DMEM_PERF_EN
    logic [15:0] load_cnt;
    logic [15:0] store_cnt;
`endif

    dmem_ctrl #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT)
    ) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .dmem    (u_if)
`ifdef DMEM_PERF_EN
        ,
        .o_load_cnt  (load_cnt),
        .o_store_cnt (store_cnt)
`endif
    );

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] mdl_mem [DEPTH];
    logic [31:0] mdl_rdata;
    int          mdl_loads;
    int          mdl_stores;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic bit mdl_legal(input bit rd, input bit wr, input logic [2:0] f3,
                                     input logic [31:0] a);
        int unsigned size;
        if (!rd && !wr) return 1'b0;
        if (rd && wr) return 1'b0;
        if (wr && f3 > 3'd2) return 1'b0;
        if (rd && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b0;
        size = 1 << f3[1:0];
        return (a % size) == 0;
    endfunction

    function automatic logic [31:0] mdl_load(input logic [31:0] a, input logic [2:0] f3);
        int unsigned w, v, off;
        w   = mdl_mem[(a >> 2) % DEPTH];
        off = a & 3;
        case (f3)
            3'd0: begin v = (w >> (8 * off)) & 'hFF;   if (v >= 'h80)   v = v + 32'hFFFF_FF00; end
            3'd4: v = (w >> (8 * off)) & 'hFF;
            3'd1: begin v = (w >> (8 * off)) & 'hFFFF; if (v >= 'h8000) v = v + 32'hFFFF_0000; end
            3'd5: v = (w >> (8 * off)) & 'hFFFF;
            default: v = w;
        endcase
        return v;
    endfunction

    task automatic mdl_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd);
        int unsigned idx, off, size, k;
        int unsigned w;
        idx  = (a >> 2) % DEPTH;
        off  = a & 3;
        size = 1 << f3[1:0];
        w    = mdl_mem[idx];
        for (int i = 0; i < int'(size); i++) begin
            k = off + i;
            w = (w & ~(32'hFF << (8 * k))) | (((wd >> (8 * i)) & 32'hFF) << (8 * k));
        end
        mdl_mem[idx] = w;
    endtask

    task automatic drive_idle();
        u_if.mem_read  = 1'b0;
        u_if.mem_write = 1'b0;
        u_if.funct3    = 3'd0;
        u_if.addr      = 32'h0;
        u_if.wdata     = 32'h0;
    endtask

    // Entered and left 1ns after a rising edge with the controller idle.
    task automatic txn(input bit rd, input bit wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input string tag);
        bit legal;
        legal = mdl_legal(rd, wr, f3, a);
        u_if.mem_read  = rd;
        u_if.mem_write = wr;
        u_if.funct3    = f3;
        u_if.addr      = a;
        u_if.wdata     = wd;
        @(negedge clk);
        check_eq({tag, ":fault"}, 32'(u_if.fault), 32'(!legal && (rd || wr)));
        check_eq({tag, ":stall"}, 32'(u_if.stall), 32'(legal));
        if (!legal) begin
            check_eq({tag, ":rdata_hold"}, u_if.rdata, mdl_rdata);
            @(posedge clk); #1;
            drive_idle();
            return;
        end
        for (int i = 1; i < LAT; i++) begin
            @(posedge clk); @(negedge clk);
            check_eq({tag, ":stall_busy"}, 32'(u_if.stall), 32'd1);
        end
        @(posedge clk); @(negedge clk);
        if (rd) begin
            mdl_rdata = mdl_load(a, f3);
            if (mdl_loads < 65535) mdl_loads++;
        end else begin
            mdl_store(a, f3, wd);
            if (mdl_stores < 65535) mdl_stores++;
        end
        check_eq({tag, ":stall_done"}, 32'(u_if.stall), 32'd0);
        check_eq({tag, ":rdata"}, u_if.rdata, mdl_rdata);
        @(posedge clk); #1;
        drive_idle();
`ifdef DMEM_PERF_EN
        check_eq({tag, ":ld_cnt"}, 32'(load_cnt), 32'(mdl_loads));
        check_eq({tag, ":st_cnt"}, 32'(store_cnt), 32'(mdl_stores));
`endif
    endtask

    initial begin
        bit          rd, wr;
        logic [2:0]  f3;
        logic [31:0] a;
        drive_idle();
        mdl_rdata  = 32'h0;
        mdl_loads  = 0;
        mdl_stores = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset:stall", 32'(u_if.stall), 32'd0);
        check_eq("reset:fault", 32'(u_if.fault), 32'd0);
        check_eq("reset:rdata", u_if.rdata, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < DEPTH; i++) txn(1'b0, 1'b1, F3_W, 32'(i * 4), $urandom, "init");

        txn(0, 1, F3_W,  32'h10, 32'hDEADBEEF, "sw10");
        txn(1, 0, F3_W,  32'h10, 32'h0, "lw10");
        txn(1, 0, F3_B,  32'h13, 32'h0, "lb13");
        txn(1, 0, F3_BU, 32'h13, 32'h0, "lbu13");
        txn(1, 0, F3_H,  32'h10, 32'h0, "lh10");
        txn(1, 0, F3_HU, 32'h12, 32'h0, "lhu12");
        txn(0, 1, F3_B,  32'h11, 32'h55, "sb11");
        txn(1, 0, F3_W,  32'h10, 32'h0, "lw10b");
        txn(0, 1, F3_H,  32'h12, 32'h1234, "sh12");
        txn(1, 0, F3_W,  32'h10, 32'h0, "lw10c");
        check_eq("plan:final_word", mdl_rdata, 32'h123455EF);
        txn(1, 0, F3_W,  32'h11, 32'h0, "f_lw11");
        txn(0, 1, F3_H,  32'h13, 32'hFFFF, "f_sh13");
        txn(1, 0, 3'd3,  32'h10, 32'h0, "f_ld011");
        txn(1, 1, F3_W,  32'h10, 32'h0, "f_rw");
        txn(1, 0, F3_W,  32'h10, 32'h0, "lw_after_f");

        // Reset during BUSY of a store: the store must be dropped.
        u_if.mem_write = 1'b1;
        u_if.funct3    = F3_W;
        u_if.addr      = 32'h20;
        u_if.wdata     = 32'hFFFFFFFF;
        @(negedge clk);
        check_eq("rst_mid:stall_t", 32'(u_if.stall), 32'd1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid:stall", 32'(u_if.stall), 32'd0);
        check_eq("rst_mid:fault", 32'(u_if.fault), 32'd0);
        check_eq("rst_mid:rdata", u_if.rdata, 32'h0);
        drive_idle();
        mdl_rdata  = 32'h0;
        mdl_loads  = 0;
        mdl_stores = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        txn(1, 0, F3_W, 32'h20, 32'h0, "lw20_kept");

        txn(0, 1, F3_W, 32'h800, 32'hA5A5A5A5, "sw800");
        txn(1, 0, F3_W, 32'h000, 32'h0, "lw000_wrap");
        check_eq("wrap:value", mdl_rdata, 32'hA5A5A5A5);

        for (int n = 0; n < 400; n++) begin
            rd = ($urandom_range(0, 1) == 1);
            wr = !rd;
            if ($urandom_range(0, 19) == 0) begin rd = 1'b1; wr = 1'b1; end
            f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
            if (rd && !wr && $urandom_range(0, 1) == 1 && f3 != 3'd2) f3 = f3 | 3'b100;
            a = {$urandom_range(0, 3) == 0 ? 32'($urandom) & 32'hFFFF_F000 : 32'h0}
                | 32'($urandom_range(0, 63));
            if ($urandom_range(0, 2) != 0) a = a & ~32'((1 << f3[1:0]) - 1);
            txn(rd, wr, f3, a, $urandom, "rnd");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        n_bad++;
        $display("FAIL timeout got=%08h exp=%08h", 32'd0, 32'd1);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
